// File: rtl/port_out_reg_if.sv
// Purpose: serial port bundle between the per-input side (arbiter grants plus
// frame/valid/data lanes) and the registered output of one switch port.
// Signals:
//   grant, frame_n, valid_n, din  per-input lanes, NUM_IN wide
//   busy_out                      port currently owned by an input
//   frameo_n, valido_n, dout      registered serial output
// Modports: master drives the input lanes; slave is the port_out_reg side.
interface port_out_reg_if #(
  parameter int unsigned NUM_IN = 16
);
  logic [NUM_IN-1:0] grant;
  logic [NUM_IN-1:0] frame_n;
  logic [NUM_IN-1:0] valid_n;
  logic [NUM_IN-1:0] din;
  logic              busy_out;
  logic              frameo_n;
  logic              valido_n;
  logic              dout;

  modport master (
    output grant, frame_n, valid_n, din,
    input  busy_out, frameo_n, valido_n, dout
  );

  modport slave (
    input  grant, frame_n, valid_n, din,
    output busy_out, frameo_n, valido_n, dout
  );
endinterface

// File: rtl/port_out_reg.sv
// Purpose: output-port register stage of a serial crossbar. On a grant in IDLE
// it locks onto the lowest granted input and forwards that input's
// frame/valid/data with one cycle of latency until the last bit or an abort.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   bus             port_out_reg_if slave: input lanes in, serial output out
//   sel_idx         index of the owning input (0 when idle)
//   err_multi       one-cycle pulse on a multi-hot grant accepted in IDLE
//   err_abort       one-cycle pulse when the owner's grant drops mid-packet
//   pkt_cnt         saturating count of completed packets
module port_out_reg #(
  parameter int unsigned NUM_IN = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  port_out_reg_if.slave             bus,
  output logic [$clog2(NUM_IN)-1:0] sel_idx,
  output logic                      err_multi,
  output logic                      err_abort,
  output logic [CNT_W-1:0]          pkt_cnt
);

  localparam int unsigned SEL_W = $clog2(NUM_IN);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   low_idx;
  logic               any_grant;
  logic               multi_grant;
  logic [SEL_W-1:0]   cur_idx;
  logic               cur_frame_n;
  logic               cur_valid_n;
  logic               cur_din;
  logic               own_grant;

  // Lowest set grant bit; scan from the top so the lowest index wins.
  always_comb begin
    low_idx = '0;
    for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
      if (bus.grant[i]) low_idx = SEL_W'(i);
    end
  end

  // A value with more than one bit set survives clearing its lowest set bit.
  assign any_grant   = |bus.grant;
  assign multi_grant = |(bus.grant & (bus.grant - NUM_IN'(1)));

  // In IDLE the lane about to be latched is forwarded on the same edge.
  assign cur_idx     = (state == IDLE) ? low_idx : sel_idx;
  assign cur_frame_n = bus.frame_n[cur_idx];
  assign cur_valid_n = bus.valid_n[cur_idx];
  assign cur_din     = bus.din[cur_idx];
  assign own_grant   = bus.grant[sel_idx];

  // State machine with every output registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bus.busy_out <= 1'b0;
      bus.frameo_n <= 1'b1;
      bus.valido_n <= 1'b1;
      bus.dout     <= 1'b0;
      sel_idx      <= '0;
      err_multi    <= 1'b0;
      err_abort    <= 1'b0;
      pkt_cnt      <= '0;
    end else begin
      err_multi <= 1'b0;
      err_abort <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_grant) begin
            state        <= XFER;
            sel_idx      <= low_idx;
            bus.busy_out <= 1'b1;
            bus.frameo_n <= cur_frame_n;
            bus.valido_n <= cur_valid_n;
            bus.dout     <= cur_din;
            err_multi    <= multi_grant;
          end else begin
            sel_idx      <= '0;
            bus.busy_out <= 1'b0;
            bus.frameo_n <= 1'b1;
            bus.valido_n <= 1'b1;
            bus.dout     <= 1'b0;
          end
        end
        XFER: begin
          if (!own_grant) begin
            // Abort wins over a coincident last bit; the packet is not counted.
            state        <= IDLE;
            sel_idx      <= '0;
            bus.busy_out <= 1'b0;
            bus.frameo_n <= 1'b1;
            bus.valido_n <= 1'b1;
            bus.dout     <= 1'b0;
            err_abort    <= 1'b1;
          end else begin
            bus.frameo_n <= cur_frame_n;
            bus.valido_n <= cur_valid_n;
            bus.dout     <= cur_din;
            // busy_out stays high while the last bit is on the output.
            if (cur_frame_n && !cur_valid_n) begin
              state <= IDLE;
              if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_out_reg.sv
// Purpose: directed bench for port_out_reg. A 16-bit-counter instance and a
// 2-bit-counter instance see identical stimulus; the second exercises
// counter saturation.
module tb_port_out_reg;

  logic clock;
  logic reset_n;

  port_out_reg_if #(.NUM_IN(16)) bus_a ();
  port_out_reg_if #(.NUM_IN(16)) bus_b ();

  logic [3:0]  sel_a, sel_b;
  logic        err_multi_a, err_multi_b;
  logic        err_abort_a, err_abort_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  port_out_reg #(.NUM_IN(16), .CNT_W(16)) dut_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus_a.slave),
    .sel_idx   (sel_a),
    .err_multi (err_multi_a),
    .err_abort (err_abort_a),
    .pkt_cnt   (cnt_a)
  );

  port_out_reg #(.NUM_IN(16), .CNT_W(2)) dut_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus_b.slave),
    .sel_idx   (sel_b),
    .err_multi (err_multi_b),
    .err_abort (err_abort_b),
    .pkt_cnt   (cnt_b)
  );

  assign bus_b.grant   = bus_a.grant;
  assign bus_b.frame_n = bus_a.frame_n;
  assign bus_b.valid_n = bus_a.valid_n;
  assign bus_b.din     = bus_a.din;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic busy, input logic fo,
                           input logic vo, input logic d, input logic [3:0] sel);
    check({tag, "/busy"}, 32'(bus_a.busy_out), 32'(busy));
    check({tag, "/frameo_n"}, 32'(bus_a.frameo_n), 32'(fo));
    check({tag, "/valido_n"}, 32'(bus_a.valido_n), 32'(vo));
    check({tag, "/dout"}, 32'(bus_a.dout), 32'(d));
    check({tag, "/sel"}, 32'(sel_a), 32'(sel));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    bus_a.grant   = '0;
    bus_a.frame_n = '1;
    bus_a.valid_n = '1;
    bus_a.din     = '0;
  endtask

  // Other lanes carry din=1 so a wrong mux select shows up on zero bits.
  task automatic drive(input int idx, input logic f, input logic v, input logic d);
    bus_a.frame_n      = '1;
    bus_a.valid_n      = '1;
    bus_a.din          = '1;
    bus_a.frame_n[idx] = f;
    bus_a.valid_n[idx] = v;
    bus_a.din[idx]     = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int         busy_cycles;

    // Reset state
    reset_n = 1'b0;
    idle_in();
    #12;
    check_out("reset", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check("reset/err_multi", 32'(err_multi_a), 32'd0);
    check("reset/err_abort", 32'(err_abort_a), 32'd0);
    check("reset/cnt", 32'(cnt_a), 32'd0);
    reset_n = 1'b1;
    tick();
    check_out("idle", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

    // Single 8-bit packet on input 3
    pat = 8'b1011_0010;
    busy_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      bus_a.grant = 16'h0008;
      drive(3, (i == 7), 1'b0, pat[7-i]);
      tick();
      if (bus_a.busy_out) busy_cycles++;
      check_out($sformatf("single/bit%0d", i), 1'b1, (i == 7), 1'b0, pat[7-i], 4'd3);
    end
    idle_in();
    tick();
    check_out("single/after", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check("single/busy_cycles", 32'(busy_cycles), 32'd8);
    check("single/cnt", 32'(cnt_a), 32'd1);

    // Multi-hot grant: input 4 wins, input 10 noise is ignored
    for (int i = 0; i < 4; i++) begin
      bus_a.grant = 16'h0410;
      drive(4, (i == 3), 1'b0, 1'b0);
      bus_a.frame_n[10] = 1'b0;
      bus_a.valid_n[10] = 1'b0;
      tick();
      check_out($sformatf("multi/bit%0d", i), 1'b1, (i == 3), 1'b0, 1'b0, 4'd4);
      check($sformatf("multi/err%0d", i), 32'(err_multi_a), 32'(i == 0));
    end
    idle_in();
    tick();
    check("multi/cnt", 32'(cnt_a), 32'd2);
    check("multi/err_after", 32'(err_multi_a), 32'd0);

    // Abort on input 5, with a stall bit and stray grant on input 0
    bus_a.grant = 16'h0020;
    drive(5, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("abort/bit1", 1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
    bus_a.grant = 16'h0021;
    drive(5, 1'b0, 1'b1, 1'b1);
    tick();
    check_out("abort/stall", 1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
    drive(5, 1'b0, 1'b0, 1'b0);
    tick();
    check_out("abort/bit2", 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
    bus_a.grant = 16'h0020;
    drive(5, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("abort/bit3", 1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
    // Grant drops while a last-bit pattern is presented: abort wins
    bus_a.grant = 16'h0000;
    drive(5, 1'b1, 1'b0, 1'b1);
    tick();
    check_out("abort/drop", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check("abort/err", 32'(err_abort_a), 32'd1);
    check("abort/cnt", 32'(cnt_a), 32'd2);
    idle_in();
    tick();
    check("abort/err_after", 32'(err_abort_a), 32'd0);
    check("abort/cnt_after", 32'(cnt_a), 32'd2);

    // Back-to-back: input 0 packet, then input 15 right after the last bit
    pat = 8'b1010_0000;
    for (int i = 0; i < 3; i++) begin
      bus_a.grant = 16'h0001;
      drive(0, (i == 2), 1'b0, pat[7-i]);
      tick();
      check_out($sformatf("b2b0/bit%0d", i), 1'b1, (i == 2), 1'b0, pat[7-i], 4'd0);
    end
    pat = 8'b0110_0000;
    for (int i = 0; i < 3; i++) begin
      bus_a.grant = 16'h8000;
      drive(15, (i == 2), 1'b0, pat[7-i]);
      tick();
      check_out($sformatf("b2b15/bit%0d", i), 1'b1, (i == 2), 1'b0, pat[7-i], 4'd15);
      if (i == 0) check("b2b/cnt_mid", 32'(cnt_a), 32'd3);
    end
    idle_in();
    tick();
    check("b2b/cnt", 32'(cnt_a), 32'd4);
    check("b2b/busy_after", 32'(bus_a.busy_out), 32'd0);

    // Asynchronous reset between edges mid-packet
    bus_a.grant = 16'h0080;
    drive(7, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("areset/bit1", 1'b1, 1'b0, 1'b0, 1'b1, 4'd7);
    drive(7, 1'b0, 1'b0, 1'b1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_out("areset/async", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check("areset/cnt_a", 32'(cnt_a), 32'd0);
    check("areset/cnt_b", 32'(cnt_b), 32'd0);
    check("areset/err_abort", 32'(err_abort_a), 32'd0);
    idle_in();
    #2;
    reset_n = 1'b1;
    tick();
    check_out("areset/release", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    check("areset/err_after", 32'(err_abort_a), 32'd0);

    // Saturation: five 2-bit packets on input 1
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 2; i++) begin
        bus_a.grant = 16'h0002;
        drive(1, (i == 1), 1'b0, 1'(i));
        tick();
      end
      idle_in();
      tick();
      check($sformatf("sat/cnt_b%0d", p), 32'(cnt_b), (p < 2) ? 32'(p + 1) : 32'd3);
      check($sformatf("sat/cnt_a%0d", p), 32'(cnt_a), 32'(p + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_out_reg.md
PORT_OUT_REG -- requirements
Module: port_out_reg

Interface
REQ-001 Parameter NUM_IN, default 16: number of input ports that can be granted to this output (2..32).
REQ-002 Parameter CNT_W, default 16: width of the completed-packet counter.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 grant  input  NUM_IN  per-input grant from the arbiter; one-hot expected.
REQ-006 frame_n  input  NUM_IN  per-input frame, active-low; goes high coincident with the last bit.
REQ-007 valid_n  input  NUM_IN  per-input bit valid, active-low.
REQ-008 din  input  NUM_IN  per-input serial data.
REQ-009 busy_out  output  1  high while the port is owned by an input.
REQ-010 frameo_n  output  1  registered output frame, active-low.
REQ-011 valido_n  output  1  registered output valid, active-low.
REQ-012 dout  output  1  registered output data.
REQ-013 sel_idx  output  $clog2(NUM_IN)  index of the owning input; 0 when idle.
REQ-014 err_multi  output  1  one-cycle pulse on a multi-hot grant accepted in IDLE.
REQ-015 err_abort  output  1  one-cycle pulse when the grant drops mid-packet.
REQ-016 pkt_cnt  output  CNT_W  count of completed packets; saturates at all-ones.

Function
REQ-017 The FSM SHALL have two states, IDLE and XFER, with all outputs registered.
REQ-018 In IDLE with grant == 0: frameo_n=1, valido_n=1, dout=0, busy_out=0; none driven to z or x.
REQ-019 In IDLE with grant != 0: latch s = lowest set grant bit into sel_idx; go to XFER; same edge registers frameo_n/valido_n/dout from frame_n[s]/valid_n[s]/din[s]; busy_out=1.
REQ-020 Multi-hot grant in IDLE: select lowest index per REQ-019 and pulse err_multi for one cycle.
REQ-021 In XFER: each edge registers frame_n[sel]/valid_n[sel]/din[sel] to the outputs; latency input->output exactly 1 cycle.
REQ-022 In XFER, changes to grant bits other than grant[sel] SHALL be ignored; no re-arbitration mid-packet.
REQ-023 Last bit: in XFER, frame_n[sel]=1 and valid_n[sel]=0 -> forward that bit (frameo_n=1, valido_n=0); go to IDLE; busy_out=0 from the next edge; pkt_cnt += 1 unless saturated.
REQ-024 After a last bit, the next cycle SHALL apply REQ-018/REQ-019 normally; one idle cycle is the minimum packet gap.
REQ-025 Abort: in XFER with grant[sel]=0 and no last bit, register frameo_n=1, valido_n=1, dout=0; pulse err_abort; go to IDLE; pkt_cnt unchanged.
REQ-026 Abort takes priority over last-bit detection in the same cycle.
REQ-027 In XFER, valid_n[sel]=1 with frame_n[sel]=0 SHALL be forwarded as a stall bit (valido_n=1, frameo_n=0); no state change.
REQ-028 pkt_cnt SHALL hold at 2^CNT_W-1 once reached; no wrap-around.

Reset
REQ-029 On reset_n=0, immediately and independent of clock: state=IDLE, busy_out=0, frameo_n=1, valido_n=1, dout=0, sel_idx=0, err_multi=0, err_abort=0, pkt_cnt=0.
REQ-030 Reset asserted mid-packet SHALL drop the packet silently: no err_abort, no pkt_cnt increment; the first edge after release behaves as IDLE.

Verification
REQ-031 Single packet: grant=0x0008, input 3 sends 8 bits with frame_n high on bit 8 -> busy_out high for 8 cycles, dout equals input-3 data delayed 1 cycle, pkt_cnt=1, sel_idx=3.
REQ-032 Multi-hot: grant=0x0410 in IDLE -> sel_idx=4, err_multi pulses once, input-10 activity does not reach dout.
REQ-033 Abort: grant[5] drops after bit 3 of 8 -> next edge frameo_n=1, valido_n=1, err_abort pulse, busy_out=0, pkt_cnt unchanged.
REQ-034 Back-to-back: packet on input 0 ends, grant=0x8000 next cycle -> sel_idx=15 one cycle after the last bit; no bit lost or duplicated.
REQ-035 Saturation: CNT_W=2, five packets -> pkt_cnt sequence 1,2,3,3,3.
REQ-036 Async reset: assert reset_n between clock edges mid-packet -> outputs reach REQ-029 values before the next edge; pkt_cnt=0.
